// File: rtl/pgm_wr.sv
// rtl/pgm_wr.sv - PGM write side: bypass forwarding, PGM RAM loading, cfg register access
//
// Purpose:
//   Classifies incoming packets as either PGM load packets (written into the
//   128-entry PGM RAM) or bypass packets (forwarded to pgm_rd one cycle later).
//   A cfg packet interface gives register access for START/STOP control of the
//   PGM send phase, a run duration, and a status word.
//
// Optional feature:
//   PGM_WR_STAT_EN - when defined, adds stored/bypass/drop packet counters
//                    readable at cfg addresses 0x20/0x21/0x22.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_wr_data/_wr                    packet words ([133:132] 01 head, 11 middle, 10 tail)
//   in_wr_valid/_wr, in_wr_phv/_wr    packet-valid word and PHV with strobes
//   out_wr_alf, out_wr_phv_alf        almost-full to upstream (pass-through)
//   out_wr_data/_wr, out_wr_valid/_wr, out_wr_phv/_wr   bypass stream to pgm_rd
//   in_wr_alf, in_wr_phv_alf          downstream almost-full
//   pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag   control to pgm_rd
//   wr2ram_wr, wr2ram_addr, wr2ram_wdata                        PGM RAM write port
//   cin_wr_data/_wr, cout_wr_ready    cfg packet input
//   cout_wr_data/_wr, cin_wr_ready    cfg packet output

module pgm_wr #(
   parameter logic [7:0] LMID = 8'd61
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [133:0]   in_wr_data,
   input  logic           in_wr_data_wr,
   input  logic           in_wr_valid,
   input  logic           in_wr_valid_wr,
   input  logic [1023:0]  in_wr_phv,
   input  logic           in_wr_phv_wr,
   output logic           out_wr_alf,
   output logic           out_wr_phv_alf,
   output logic [133:0]   out_wr_data,
   output logic           out_wr_data_wr,
   output logic           out_wr_valid,
   output logic           out_wr_valid_wr,
   output logic [1023:0]  out_wr_phv,
   output logic           out_wr_phv_wr,
   input  logic           in_wr_alf,
   input  logic           in_wr_phv_alf,
   output logic           pgm_bypass_flag,
   output logic           pgm_sent_start_flag,
   output logic           pgm_sent_finish_flag,
   output logic           wr2ram_wr,
   output logic [6:0]     wr2ram_addr,
   output logic [143:0]   wr2ram_wdata,
   input  logic [133:0]   cin_wr_data,
   input  logic           cin_wr_data_wr,
   output logic           cout_wr_ready,
   output logic [133:0]   cout_wr_data,
   output logic           cout_wr_data_wr,
   input  logic           cin_wr_ready
);

   typedef enum logic [2:0] {IDLE, BYPASS, STORE, DROP, SEND, DONE} state_t;

   state_t        state, state_nxt;
   logic [6:0]    wr_addr;
   logic [6:0]    word_cnt;
   logic          pgm_valid;
   logic [31:0]   timer;
   logic [31:0]   duration;
   logic          soft_rst;

   assign out_wr_alf     = in_wr_alf;
   assign out_wr_phv_alf = in_wr_phv_alf;
   assign cout_wr_ready  = cin_wr_ready;

   // datapath word decode
   logic in_head, in_tail, is_load;
   assign in_head = (in_wr_data[133:132] == 2'b01);
   assign in_tail = (in_wr_data[133:132] == 2'b10);
   assign is_load = (in_wr_data[103:96] == LMID) && (in_wr_data[126:124] == 3'b100);

   // cfg head decode
   logic          c_head, c_wr, c_rd;
   logic [31:0]   c_addr, c_wdata;
   logic          soft_req, start_ok, stop_cmd, dur_wr, finish_hit;
   logic [31:0]   timer_inc;

   assign c_head    = cin_wr_data_wr && (cin_wr_data[133:132] == 2'b01) && (cin_wr_data[103:96] == LMID);
   assign c_wr      = c_head && (cin_wr_data[126:124] == 3'b010);
   assign c_rd      = c_head && (cin_wr_data[126:124] == 3'b001);
   assign c_addr    = cin_wr_data[95:64];
   assign c_wdata   = cin_wr_data[31:0];
   assign soft_req  = c_wr && (c_addr == 32'h0) && c_wdata[0];
   assign start_ok  = c_wr && (c_addr == 32'h10) && (state == IDLE) && pgm_valid;
   assign stop_cmd  = c_wr && (c_addr == 32'h11);
   assign dur_wr    = c_wr && (c_addr == 32'h12);
   assign timer_inc = timer + 32'd1;
   // timer_inc is the value the timer takes this edge, so the finish flag rises
   // together with the timer reaching duration
   assign finish_hit = (state == SEND) && (stop_cmd || ((duration != 32'd0) && (timer_inc == duration)));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else if (soft_req)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_ok)
               state_nxt = SEND;
            else if (in_wr_data_wr && in_head)
               state_nxt = is_load ? STORE : BYPASS;
         end
         BYPASS: if (in_wr_data_wr && in_tail) state_nxt = IDLE;
         STORE: begin
            if (in_wr_data_wr) begin
               if (in_tail)
                  state_nxt = IDLE;
               else if (wr_addr == 7'd127)
                  state_nxt = DROP;
            end
         end
         DROP: if (in_wr_data_wr && in_tail) state_nxt = IDLE;
         SEND: if (finish_hit) state_nxt = DONE;
         DONE: state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // output decode
   logic       load_head, bypass_head, fwd_en, ram_we, store_done;
   logic [6:0] ram_addr;
   always_comb begin
      load_head   = (state == IDLE) && in_wr_data_wr && in_head && is_load && !start_ok;
      bypass_head = (state == IDLE) && in_wr_data_wr && in_head && !is_load && !start_ok;
      // valid/PHV strobes travel with the bypass packet they belong to
      fwd_en      = (state == BYPASS) || bypass_head;
      ram_we      = load_head || ((state == STORE) && in_wr_data_wr);
      ram_addr    = load_head ? 7'd0 : wr_addr;
      store_done  = (state == STORE) && in_wr_data_wr && in_tail;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_wr_data          <= '0;
         out_wr_data_wr       <= 1'b0;
         out_wr_valid         <= 1'b0;
         out_wr_valid_wr      <= 1'b0;
         out_wr_phv           <= '0;
         out_wr_phv_wr        <= 1'b0;
         wr2ram_wr            <= 1'b0;
         wr2ram_addr          <= '0;
         wr2ram_wdata         <= '0;
         wr_addr              <= '0;
         pgm_valid            <= 1'b0;
         word_cnt             <= '0;
         pgm_bypass_flag      <= 1'b1;
         pgm_sent_start_flag  <= 1'b0;
         pgm_sent_finish_flag <= 1'b0;
         timer                <= '0;
         duration             <= '0;
      end else if (soft_req) begin
         out_wr_data          <= '0;
         out_wr_data_wr       <= 1'b0;
         out_wr_valid         <= 1'b0;
         out_wr_valid_wr      <= 1'b0;
         out_wr_phv           <= '0;
         out_wr_phv_wr        <= 1'b0;
         wr2ram_wr            <= 1'b0;
         wr2ram_addr          <= '0;
         wr2ram_wdata         <= '0;
         wr_addr              <= '0;
         pgm_valid            <= 1'b0;
         word_cnt             <= '0;
         pgm_bypass_flag      <= 1'b1;
         pgm_sent_start_flag  <= 1'b0;
         pgm_sent_finish_flag <= 1'b0;
         timer                <= '0;
         duration             <= '0;
      end else begin
         out_wr_data_wr  <= in_wr_data_wr && fwd_en;
         if (in_wr_data_wr && fwd_en)
            out_wr_data <= in_wr_data;
         out_wr_valid_wr <= in_wr_valid_wr && fwd_en;
         if (in_wr_valid_wr && fwd_en)
            out_wr_valid <= in_wr_valid;
         out_wr_phv_wr   <= in_wr_phv_wr && fwd_en;
         if (in_wr_phv_wr && fwd_en)
            out_wr_phv <= in_wr_phv;

         wr2ram_wr <= ram_we;
         if (ram_we) begin
            wr2ram_addr  <= ram_addr;
            wr2ram_wdata <= {10'b0, in_wr_data};
            wr_addr      <= ram_addr + 7'd1;
         end

         if (load_head)
            pgm_valid <= 1'b0;
         if (store_done) begin
            pgm_valid <= 1'b1;
            word_cnt  <= ram_addr + 7'd1;
         end

         pgm_bypass_flag     <= (state_nxt != SEND) && (state_nxt != DONE);
         pgm_sent_start_flag <= start_ok;
         if (finish_hit)
            pgm_sent_finish_flag <= 1'b1;

         if (start_ok)
            timer <= '0;
         else if (state == SEND)
            timer <= timer_inc;

         if (dur_wr)
            duration <= c_wdata;
      end
   end

   // soft reset bit reads back for exactly one cycle after the write
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         soft_rst <= 1'b0;
      else
         soft_rst <= soft_req;
   end

`ifdef PGM_WR_STAT_EN
   logic [31:0] stored_pkt_cnt, bypass_pkt_cnt, drop_cnt;
   logic        drop_head, drop_tail;
   assign drop_head = in_wr_data_wr && in_head && ((state == SEND) || (state == DONE) || start_ok);
   assign drop_tail = (state == DROP) && in_wr_data_wr && in_tail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stored_pkt_cnt <= '0;
         bypass_pkt_cnt <= '0;
         drop_cnt       <= '0;
      end else if (soft_req) begin
         stored_pkt_cnt <= '0;
         bypass_pkt_cnt <= '0;
         drop_cnt       <= '0;
      end else begin
         if (store_done)
            stored_pkt_cnt <= stored_pkt_cnt + 32'd1;
         if (bypass_head)
            bypass_pkt_cnt <= bypass_pkt_cnt + 32'd1;
         if (drop_head || drop_tail)
            drop_cnt <= drop_cnt + 32'd1;
      end
   end
`endif

   logic [31:0] rd_val;
   always_comb begin
      rd_val = 32'hFFFF_FFFF;
      case (c_addr)
         32'h00: rd_val = {31'b0, soft_rst};
         32'h12: rd_val = duration;
         32'h13: rd_val = {24'b0, pgm_valid, word_cnt};
`ifdef PGM_WR_STAT_EN
         32'h20: rd_val = stored_pkt_cnt;
         32'h21: rd_val = bypass_pkt_cnt;
         32'h22: rd_val = drop_cnt;
`endif
         default: rd_val = 32'hFFFF_FFFF;
      endcase
   end

   // the cfg chain is left running through a soft reset so the soft-reset
   // write itself still propagates to the next block
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cout_wr_data    <= '0;
         cout_wr_data_wr <= 1'b0;
      end else begin
         cout_wr_data_wr <= cin_wr_data_wr;
         if (cin_wr_data_wr) begin
            if (c_rd)
               cout_wr_data <= {cin_wr_data[133:128], 4'b1011, cin_wr_data[123:32], rd_val};
            else
               cout_wr_data <= cin_wr_data;
         end
      end
   end

endmodule
